// File: rtl/dmgplus_pkg.sv
// Shared definitions for the DMG+ splash generator: FSM states, the "DMG+" signature
// and the splash image geometry.
package dmgplus_pkg;

  localparam int unsigned NUM_PIXELS      = 23040;
  localparam int unsigned BYTES_PER_IMAGE = NUM_PIXELS / 4;

  localparam logic [7:0] SIG_BYTE0 = 8'h44;
  localparam logic [7:0] SIG_BYTE1 = 8'h4D;
  localparam logic [7:0] SIG_BYTE2 = 8'h47;
  localparam logic [7:0] SIG_BYTE3 = 8'h2B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIG_RD,
    S_SIG_CHK,
    S_IMG_RD,
    S_IMG_WR,
    S_HOLD,
    S_DONE,
    S_CLEAR
  } splash_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_DRAIN,
    RD_REQ,
    RD_WAIT
  } rd_state_t;

  function automatic logic [7:0] sig_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return SIG_BYTE0;
      2'd1:    return SIG_BYTE1;
      2'd2:    return SIG_BYTE2;
      default: return SIG_BYTE3;
    endcase
  endfunction

  // The leftmost pixel of a byte sits in its top two bits.
  function automatic logic [1:0] pixel_of(input logic [7:0] b, input logic [1:0] slot);
    case (slot)
      2'd0:    return b[7:6];
      2'd1:    return b[5:4];
      2'd2:    return b[3:2];
      default: return b[1:0];
    endcase
  endfunction

endpackage

// File: rtl/dmgplus_rom_reader.sv
// Single-byte cartridge ROM reader: request/busy handshake with a synchronized busy line.
module dmgplus_rom_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        start,
  input  logic [15:0] addr,
  output logic [7:0]  data,
  output logic        done,
  output logic [15:0] rom_addr,
  output logic        rom_rd,
  input  logic [7:0]  rom_data,
  input  logic        rom_bsy
);
  import dmgplus_pkg::*;

  rd_state_t   state, state_next;
  logic        bsy_meta, bsy_sync;
  logic [15:0] addr_q;

  assign rom_addr = addr_q;
  assign rom_rd   = (state == RD_REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      bsy_meta <= 1'b0;
      bsy_sync <= 1'b0;
    end else begin
      bsy_meta <= rom_bsy;
      bsy_sync <= bsy_meta;
    end
  end

  // A busy still high from an abandoned read must clear before a new request goes out.
  always_comb begin
    state_next = state;
    case (state)
      RD_IDLE:  if (start) state_next = bsy_sync ? RD_DRAIN : RD_REQ;
      RD_DRAIN: if (!bsy_sync) state_next = RD_REQ;
      RD_REQ:   if (bsy_sync) state_next = RD_WAIT;
      RD_WAIT:  if (!bsy_sync) state_next = RD_IDLE;
      default:  state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state  <= RD_IDLE;
      addr_q <= 16'h0000;
      data   <= 8'h00;
      done   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      if (state == RD_IDLE && start) addr_q <= addr;
      if (state == RD_WAIT && !bsy_sync) begin
        data <= rom_data;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmgplus_splash_gen.sv
// DMG+ boot splash: checks the ROM signature, streams the 2bpp image into VRAM, holds it
// for a number of frames. Define DMGPLUS_CLEAR_EN to blank VRAM on a signature mismatch.
module dmgplus_splash_gen #(
  parameter logic [15:0] SIG_ADDR      = 16'h0200,
  parameter int unsigned SPLASH_FRAMES = 120,
  parameter int unsigned NUM_PIXELS    = dmgplus_pkg::NUM_PIXELS
) (
  input  logic        clk_8m,
  input  logic        rst,
  input  logic        ena,
  input  logic        in_vblank,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        rom_rd,
  input  logic        rom_bsy,
  output logic        vramclk,
  output logic [15:0] vramaddr,
  output logic [1:0]  vramdata,
  output logic        vramwe,
  output logic        is_dmgplus,
  output logic        rom_read_done,
  output logic        splash_done
);
  import dmgplus_pkg::*;

  localparam logic [14:0] LAST_PIX   = 15'(NUM_PIXELS - 1);
  localparam logic [7:0]  LAST_FRAME = 8'(SPLASH_FRAMES - 1);

  splash_state_t state, state_next;
  logic [15:0]   byte_addr;
  logic [1:0]    sig_idx;
  logic [14:0]   pix_cnt;
  logic [7:0]    frame_cnt;
  logic          rd_start, rd_done;
  logic [7:0]    rd_data;
  logic          vb_meta, vb_sync, vb_prev, vb_edge;
  logic          sig_match, pix_last, burst_last;

  assign vramclk    = clk_8m;
  assign vb_edge    = vb_sync & ~vb_prev;
  assign sig_match  = (rd_data == sig_byte(sig_idx));
  assign pix_last   = (pix_cnt == LAST_PIX);
  assign burst_last = (pix_cnt[1:0] == 2'd3);

  dmgplus_rom_reader u_reader (
    .clk      (clk_8m),
    .rst      (rst),
    .abort    (~ena),
    .start    (rd_start),
    .addr     (byte_addr),
    .data     (rd_data),
    .done     (rd_done),
    .rom_addr (rom_addr),
    .rom_rd   (rom_rd),
    .rom_data (rom_data),
    .rom_bsy  (rom_bsy)
  );

  always_ff @(posedge clk_8m) begin
    if (rst) begin
      vb_meta <= 1'b0;
      vb_sync <= 1'b0;
      vb_prev <= 1'b0;
    end else begin
      vb_meta <= in_vblank;
      vb_sync <= vb_meta;
      vb_prev <= vb_sync;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (ena) state_next = S_SIG_RD;
      S_SIG_RD:  if (rd_done) state_next = S_SIG_CHK;
      S_SIG_CHK: begin
        if (!sig_match)
`ifdef DMGPLUS_CLEAR_EN
          state_next = S_CLEAR;
`else
          state_next = S_DONE;
`endif
        else if (sig_idx == 2'd3)
          state_next = S_IMG_RD;
        else
          state_next = S_SIG_RD;
      end
      S_IMG_RD:  if (rd_done) state_next = S_IMG_WR;
      S_IMG_WR:  if (burst_last) state_next = pix_last ? S_HOLD : S_IMG_RD;
      S_HOLD:    if (vb_edge && frame_cnt == LAST_FRAME) state_next = S_DONE;
      S_DONE:    state_next = S_DONE;
      S_CLEAR:   if (pix_last) state_next = S_DONE;
      default:   state_next = S_IDLE;
    endcase
    if (!ena) state_next = S_IDLE;
  end

  always_comb begin
    vramwe   = 1'b0;
    vramaddr = 16'h0000;
    vramdata = 2'b00;
    if (state == S_IMG_WR) begin
      vramwe   = 1'b1;
      vramaddr = {1'b0, pix_cnt};
      vramdata = pixel_of(rd_data, pix_cnt[1:0]);
    end else if (state == S_CLEAR) begin
      vramwe   = 1'b1;
      vramaddr = {1'b0, pix_cnt};
    end
  end

  // A fresh read is launched on every entry into a read state, so one start per byte.
  always_ff @(posedge clk_8m) begin
    if (rst) begin
      state         <= S_IDLE;
      rd_start      <= 1'b0;
      byte_addr     <= SIG_ADDR;
      sig_idx       <= 2'd0;
      pix_cnt       <= 15'd0;
      frame_cnt     <= 8'd0;
      is_dmgplus    <= 1'b0;
      rom_read_done <= 1'b0;
      splash_done   <= 1'b0;
    end else begin
      state    <= state_next;
      rd_start <= (state_next == S_SIG_RD || state_next == S_IMG_RD) && (state_next != state);
      if (!ena || state == S_IDLE) begin
        byte_addr     <= SIG_ADDR;
        sig_idx       <= 2'd0;
        pix_cnt       <= 15'd0;
        frame_cnt     <= 8'd0;
        is_dmgplus    <= 1'b0;
        rom_read_done <= 1'b0;
        splash_done   <= 1'b0;
      end else begin
        case (state)
          S_SIG_CHK: begin
            if (sig_match) begin
              byte_addr <= byte_addr + 16'd1;
              sig_idx   <= sig_idx + 2'd1;
              if (sig_idx == 2'd3) is_dmgplus <= 1'b1;
            end else begin
              pix_cnt <= 15'd0;
`ifndef DMGPLUS_CLEAR_EN
              rom_read_done <= 1'b1;
              splash_done   <= 1'b1;
`endif
            end
          end
          S_IMG_WR: begin
            pix_cnt <= pix_cnt + 15'd1;
            if (burst_last) begin
              if (pix_last) begin
                rom_read_done <= 1'b1;
                frame_cnt     <= 8'd0;
              end else begin
                byte_addr <= byte_addr + 16'd1;
              end
            end
          end
          S_HOLD: begin
            if (vb_edge) begin
              frame_cnt <= frame_cnt + 8'd1;
              if (frame_cnt == LAST_FRAME) splash_done <= 1'b1;
            end
          end
          S_CLEAR: begin
            pix_cnt <= pix_cnt + 15'd1;
            if (pix_last) begin
              rom_read_done <= 1'b1;
              splash_done   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmgplus_splash_gen.sv
// Bench for dmgplus_splash_gen: ROM responder plus VRAM write scoreboard, directed phases
// for reset, signature mismatch, full image load, frame hold, abort and restart.
`timescale 1ns/100ps
module tb_dmgplus_splash_gen;

  localparam logic [15:0] SIG_ADDR  = 16'h0200;
  localparam int          IMG_BYTES = 5760;
  localparam int          PIXELS    = 23040;

  logic        clk_8m = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        in_vblank = 1'b0;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic        rom_rd;
  logic        rom_bsy = 1'b0;
  logic        vramclk;
  logic [15:0] vramaddr;
  logic [1:0]  vramdata;
  logic        vramwe;
  logic        is_dmgplus, rom_read_done, splash_done;

  int          n_assert = 0;
  int          n_fail = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  int          extra_rd = 0;
  int          extra_wr = 0;
  logic [15:0] last_rd_addr = 16'hFFFF;
  bit          img_rom = 1'b0;
  bit          rd_seen = 1'b0;
  logic [15:0] exp_rd[$];
  logic [17:0] exp_pix[$];
  logic [17:0] pix_e;

  dmgplus_splash_gen dut (
    .clk_8m        (clk_8m),
    .rst           (rst),
    .ena           (ena),
    .in_vblank     (in_vblank),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .rom_rd        (rom_rd),
    .rom_bsy       (rom_bsy),
    .vramclk       (vramclk),
    .vramaddr      (vramaddr),
    .vramdata      (vramdata),
    .vramwe        (vramwe),
    .is_dmgplus    (is_dmgplus),
    .rom_read_done (rom_read_done),
    .splash_done   (splash_done)
  );

  always #62.5 clk_8m = ~clk_8m;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic v, input int cycles);
    ena       = e;
    in_vblank = v;
    repeat (cycles) @(negedge clk_8m);
  endtask

  function automatic logic [7:0] romByte(input logic [15:0] a);
    if (!img_rom) return a[7:0];
    case (a)
      SIG_ADDR:          return 8'h44;
      SIG_ADDR + 16'd1:  return 8'h4D;
      SIG_ADDR + 16'd2:  return 8'h47;
      SIG_ADDR + 16'd3:  return 8'h2B;
      default:           return 8'hE4;
    endcase
  endfunction

  // ROM responder: one busy pulse per request; image bytes queue their four expected pixels.
  always @(negedge clk_8m) begin
    if (rom_bsy) begin
      rom_bsy = 1'b0;
    end else if (!rst && rom_rd === 1'b1 && !rd_seen) begin
      int base;
      rd_seen      = 1'b1;
      rd_count++;
      last_rd_addr = rom_addr;
      if (exp_rd.size() > 0) checkOutput("rom_addr", rom_addr, exp_rd.pop_front());
      else extra_rd++;
      rom_data = romByte(rom_addr);
      rom_bsy  = 1'b1;
      if (img_rom && rom_addr >= SIG_ADDR + 16'd4) begin
        base = (int'(rom_addr) - int'(SIG_ADDR) - 4) * 4;
        for (int k = 0; k < 4; k++)
          exp_pix.push_back({16'(base + k), 2'((rom_data >> (6 - 2 * k)) & 8'h03)});
      end
    end
    if (rom_rd !== 1'b1) rd_seen = 1'b0;
  end

  always @(negedge clk_8m) begin
    if (!rst && vramwe === 1'b1) begin
      wr_count++;
      if (exp_pix.size() > 0) begin
        pix_e = exp_pix.pop_front();
        checkOutput("vram_addr", vramaddr, pix_e[17:2]);
        checkOutput("vram_data", vramdata, pix_e[1:0]);
      end else begin
        extra_wr++;
      end
    end
  end

  initial begin
    int n;
    $display("[TB] reset with ena high");
    exp_rd.push_back(SIG_ADDR);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("rom_rd_in_reset", rom_rd, 1'b0);
    end
    checkOutput("reset_outputs",
                {rom_addr, rom_rd, vramaddr, vramdata, vramwe, is_dmgplus, rom_read_done, splash_done}, 64'h0);
    checkOutput("vramclk", vramclk, clk_8m);

    $display("[TB] signature mismatch");
`ifdef DMGPLUS_CLEAR_EN
    for (int i = 0; i < PIXELS; i++) exp_pix.push_back({16'(i), 2'b00});
`endif
    rst = 1'b0;
    n = 0;
    while (splash_done !== 1'b1 && n < 30000) begin @(negedge clk_8m); n++; end
    checkOutput("mm_splash_done", splash_done, 1'b1);
    checkOutput("mm_read_done", rom_read_done, 1'b1);
    checkOutput("mm_is_dmgplus", is_dmgplus, 1'b0);
    applyStimulus(1'b1, 1'b0, 20);
    checkOutput("mm_read_count", rd_count, 1);
    checkOutput("mm_read_addr", last_rd_addr, SIG_ADDR);
    checkOutput("mm_extra_reads", extra_rd, 0);
`ifdef DMGPLUS_CLEAR_EN
    checkOutput("mm_clear_writes", wr_count, PIXELS);
`else
    checkOutput("mm_writes", wr_count, 0);
`endif
    checkOutput("mm_pixels_left", exp_pix.size(), 0);
    checkOutput("mm_flags_held", {is_dmgplus, rom_read_done, splash_done}, 3'b011);

    $display("[TB] valid image load");
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("idle_flags", {is_dmgplus, rom_read_done, splash_done}, 3'b000);
    exp_rd.delete();
    exp_pix.delete();
    rd_count = 0; wr_count = 0; extra_rd = 0; extra_wr = 0;
    img_rom = 1'b1;
    for (int i = 0; i < IMG_BYTES + 4; i++) exp_rd.push_back(SIG_ADDR + 16'(i));
    ena = 1'b1;
    n = 0;
    while (rom_read_done !== 1'b1 && n < 80000) begin @(negedge clk_8m); n++; end
    checkOutput("img_read_done", rom_read_done, 1'b1);
    checkOutput("img_is_dmgplus", is_dmgplus, 1'b1);
    checkOutput("img_splash_early", splash_done, 1'b0);
    checkOutput("img_read_count", rd_count, IMG_BYTES + 4);
    checkOutput("img_last_addr", last_rd_addr, 16'h1883);
    checkOutput("img_write_count", wr_count, PIXELS);
    checkOutput("img_extra", extra_rd + extra_wr, 0);
    checkOutput("img_pixels_left", exp_pix.size(), 0);

    $display("[TB] frame hold");
    for (int i = 0; i < 118; i++) begin
      applyStimulus(1'b1, 1'b1, 3);
      applyStimulus(1'b1, 1'b0, 3);
    end
    checkOutput("hold_118_edges", splash_done, 1'b0);
    applyStimulus(1'b1, 1'b1, 1000);
    checkOutput("hold_long_vblank", splash_done, 1'b0);
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("hold_119_edges", splash_done, 1'b0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("hold_edge_120_early", splash_done, 1'b0);
    applyStimulus(1'b1, 1'b1, 5);
    checkOutput("hold_edge_120", splash_done, 1'b1);
    applyStimulus(1'b1, 1'b0, 50);
    checkOutput("done_held", {is_dmgplus, rom_read_done, splash_done, vramwe}, 4'b1110);

    $display("[TB] abort mid-image");
    applyStimulus(1'b0, 1'b0, 3);
    exp_rd.delete();
    exp_pix.delete();
    rd_count = 0; wr_count = 0; extra_rd = 0; extra_wr = 0;
    for (int i = 0; i < 40; i++) exp_rd.push_back(SIG_ADDR + 16'(i));
    ena = 1'b1;
    n = 0;
    while (wr_count < 100 && n < 5000) begin @(negedge clk_8m); n++; end
    checkOutput("abort_reached", wr_count >= 100, 1'b1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("abort_outputs",
                {rom_addr, rom_rd, vramaddr, vramdata, vramwe, is_dmgplus, rom_read_done, splash_done}, 64'h0);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("abort_writes", wr_count, 100);

    $display("[TB] restart");
    exp_rd.delete();
    exp_pix.delete();
    rd_count = 0; extra_rd = 0;
    last_rd_addr = 16'hFFFF;
    exp_rd.push_back(SIG_ADDR);
    ena = 1'b1;
    n = 0;
    while (rd_count < 1 && n < 200) begin @(negedge clk_8m); n++; end
    checkOutput("restart_first_addr", last_rd_addr, SIG_ADDR);
    applyStimulus(1'b0, 1'b0, 5);
    checkOutput("final_idle", {rom_rd, vramwe, is_dmgplus, rom_read_done, splash_done}, 5'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
